// File: rtl/mph_pkg.sv
// Shared constants and types for the multi-project harness activation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mph_pkg;

    // Word offsets of the register map, relative to the wishbone base address.
    localparam logic [31:0] REG_CTRL_OFS   = 32'h0;
    localparam logic [31:0] REG_STATUS_OFS = 32'h4;
    localparam logic [31:0] REG_GUARD_OFS  = 32'h8;

    // Width of a project index (override bus and CTRL.sel).
    localparam int IDX_W = 8;

    // CTRL bit positions.
    localparam int CTRL_SEL_LSB = 0;
    localparam int CTRL_SEL_MSB = 7;
    localparam int CTRL_EN_BIT  = 31;

    // STATUS bit positions.
    localparam int STAT_CUR_MSB  = 7;
    localparam int STAT_BUSY_BIT = 8;
    localparam int STAT_ON_BIT   = 9;
    localparam int STAT_ERR_BIT  = 10;
    localparam int STAT_OVR_BIT  = 11;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

endpackage

// File: rtl/mph_sync2.sv
// Two-flop synchroniser for a bundle of quasi-static signals from another clock domain.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (async active-low), d_i (asynchronous input), q_o (synchronised output).
module mph_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mph_project_select.sv
// Wishbone-programmable one-hot project activation with break-before-make guard gap.
// Latency: ack 1 cycle after strobe; active_o follows a CTRL write 1 cycle after ack.
// Backpressure: one request per two cycles on a held strobe (no back-to-back ack).
// Ports: wishbone classic slave (wbs_*), LA override (la_override_i, la_sel_i, asynchronous),
//        active_o one-hot project enables; single clock wb_clk_i, async active-low wb_rst_ni.
module mph_project_select
    import mph_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS  = 8,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter logic [15:0] GUARD_DEFAULT = 16'd4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic                    la_override_i,
    input  logic [IDX_W-1:0]        la_sel_i,
    output logic [NUM_PROJECTS-1:0] active_o
);

    // ---------------- LA override synchronisation ----------------
    logic [IDX_W:0]   la_raw, la_sync;
    logic             ovr_s;
    logic [IDX_W-1:0] la_sel_s;

    assign la_raw = {la_override_i, la_sel_i};

    mph_sync2 #(.WIDTH(IDX_W + 1)) u_la_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d_i   (la_raw),
        .q_o   (la_sync)
    );

    assign ovr_s    = la_sync[IDX_W];
    assign la_sel_s = la_sync[IDX_W-1:0];

    // ---------------- State ----------------
    logic                    ack_d, ack_q;
    logic [31:0]             dat_d, dat_q;
    logic [IDX_W-1:0]        sel_d, sel_q;
    logic                    en_d, en_q;
    logic [15:0]             guard_d, guard_q;
    logic [15:0]             cnt_d, cnt_q;
    logic [IDX_W-1:0]        cur_d, cur_q;
    state_t                  state_d, state_q;
    logic [NUM_PROJECTS-1:0] active_d, active_q;

    // ---------------- Target resolution ----------------
    logic             req_vld, req_err, tgt_vld;
    logic [IDX_W-1:0] req_idx;

    always_comb begin
        req_vld = ovr_s | en_q;
        req_idx = ovr_s ? la_sel_s : sel_q;
        req_err = req_vld & ({{(32-IDX_W){1'b0}}, req_idx} >= NUM_PROJECTS);
        tgt_vld = req_vld & ~req_err;
    end

    // ---------------- Wishbone register file ----------------
    logic        wb_req, hit_ctrl, hit_status, hit_guard;
    logic [31:0] ctrl_word, status_word, rdata;
    logic        unused_bits;

    // Gating on ack_q spaces requests so a held strobe never gets back-to-back acks.
    assign wb_req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign hit_ctrl   = (wbs_adr_i == BASE_ADDR + REG_CTRL_OFS);
    assign hit_status = (wbs_adr_i == BASE_ADDR + REG_STATUS_OFS);
    assign hit_guard  = (wbs_adr_i == BASE_ADDR + REG_GUARD_OFS);
    assign unused_bits = ^{wbs_dat_i[30:16], wbs_sel_i[2]};

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_SEL_MSB:CTRL_SEL_LSB] = sel_q;
        ctrl_word[CTRL_EN_BIT]               = en_q;

        status_word = '0;
        status_word[STAT_CUR_MSB:0] = cur_q;
        status_word[STAT_BUSY_BIT]  = (state_q == ST_GUARD);
        status_word[STAT_ON_BIT]    = (state_q == ST_ON);
        status_word[STAT_ERR_BIT]   = req_err;
        status_word[STAT_OVR_BIT]   = ovr_s;

        rdata = '0;
        if (hit_ctrl)        rdata = ctrl_word;
        else if (hit_status) rdata = status_word;
        else if (hit_guard)  rdata = {16'h0000, guard_q};

        ack_d   = wb_req;
        dat_d   = (wb_req && !wbs_we_i) ? rdata : 32'h0;
        sel_d   = sel_q;
        en_d    = en_q;
        guard_d = guard_q;
        if (wb_req && wbs_we_i) begin
            if (hit_ctrl) begin
                if (wbs_sel_i[0]) sel_d = wbs_dat_i[CTRL_SEL_MSB:CTRL_SEL_LSB];
                if (wbs_sel_i[3]) en_d  = wbs_dat_i[CTRL_EN_BIT];
            end
            if (hit_guard) begin
                if (wbs_sel_i[0]) guard_d[7:0]  = wbs_dat_i[7:0];
                if (wbs_sel_i[1]) guard_d[15:8] = wbs_dat_i[15:8];
            end
        end
    end

    // ---------------- Activation FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        case (state_q)
            ST_OFF: begin
                if (tgt_vld) begin
                    state_d = ST_ON;
                    cur_d   = req_idx;
                end
            end
            ST_ON: begin
                if (!tgt_vld || (req_idx != cur_q)) begin
                    state_d = ST_GUARD;
                    cnt_d   = guard_q;
                end
            end
            ST_GUARD: begin
                // Counter runs to zero regardless of target changes; the target seen on
                // the final cycle is the one that gets activated.
                if (cnt_q == 16'd0) begin
                    if (tgt_vld) begin
                        state_d = ST_ON;
                        cur_d   = req_idx;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Output decoded from next state so active_o is a clean register.
        active_d = '0;
        for (int i = 0; i < int'(NUM_PROJECTS); i++) begin
            active_d[i] = (state_d == ST_ON) && (cur_d == IDX_W'(i));
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            sel_q    <= '0;
            en_q     <= 1'b0;
            guard_q  <= GUARD_DEFAULT;
            cnt_q    <= '0;
            cur_q    <= '0;
            state_q  <= ST_OFF;
            active_q <= '0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            guard_q  <= guard_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign active_o  = active_q;

endmodule

// File: tb/tb_mph_project_select.sv
module tb_mph_project_select;

    localparam int          NP   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0, cyc = 1'b0, we_s = 1'b0;
    logic [3:0]    sel_s = 4'h0;
    logic [31:0]   adr_s = 32'h0, dat_s = 32'h0;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          la_ovr = 1'b0;
    logic [7:0]    la_sel = 8'h0;
    logic [NP-1:0] active_o;

    int checks = 0;
    int errors = 0;

    mph_project_select #(
        .NUM_PROJECTS  (NP),
        .BASE_ADDR     (BASE),
        .GUARD_DEFAULT (16'd4)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we_s),
        .wbs_sel_i     (sel_s),
        .wbs_adr_i     (adr_s),
        .wbs_dat_i     (dat_s),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .la_override_i (la_ovr),
        .la_sel_i      (la_sel),
        .active_o      (active_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    // Abstract view: which project is driving (-1 = none), how many blank cycles remain
    // before the next project may take over, register contents, and a 2-deep delay line
    // for the LA inputs.
    typedef struct {
        bit          rd;
        logic [31:0] dat;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] m_ctrl = 32'h0;
    logic [15:0] m_guard = 16'd4;
    int          m_act = -1;
    int          m_cur = 0;
    int          m_black = 0;
    bit          m_acc_prev = 1'b0;
    bit          m_ack = 1'b0;
    logic [8:0]  la_pipe [2] = '{9'h0, 9'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 32'h0; m_guard = 16'd4; m_act = -1; m_cur = 0; m_black = 0;
            m_acc_prev = 1'b0; m_ack = 1'b0; la_pipe[0] = 9'h0; la_pipe[1] = 9'h0;
            sb_q.delete();
        end else begin
            bit          ovr, req, err, acc;
            int          idx, t;
            logic [31:0] st;
            sb_t         e;

            ovr = la_pipe[1][8];
            req = ovr || m_ctrl[31];
            idx = ovr ? int'(la_pipe[1][7:0]) : int'(m_ctrl[7:0]);
            err = req && (idx >= NP);
            t   = (req && !err) ? idx : -1;

            st = 32'h0;
            st[7:0] = 8'(m_cur);
            st[8]   = (m_black > 0);
            st[9]   = (m_act >= 0);
            st[10]  = err;
            st[11]  = ovr;

            acc = stb && cyc && !m_acc_prev;
            m_acc_prev = acc;
            m_ack = acc;
            if (acc) begin
                e.rd  = !we_s;
                e.dat = 32'h0;
                if (adr_s == BASE)          e.dat = m_ctrl;
                else if (adr_s == BASE + 4) e.dat = st;
                else if (adr_s == BASE + 8) e.dat = {16'h0, m_guard};
                sb_q.push_back(e);
            end

            // Project hand-over: leaving a project blanks the outputs for guard+1 cycles.
            if (m_black > 0) begin
                m_black--;
                if (m_black == 0 && t >= 0) begin m_act = t; m_cur = t; end
            end else if (m_act < 0) begin
                if (t >= 0) begin m_act = t; m_cur = t; end
            end else if (t != m_act) begin
                m_act = -1;
                m_black = int'(m_guard) + 1;
            end

            if (acc && we_s) begin
                if (adr_s == BASE) begin
                    for (int b = 0; b < 4; b++) if (sel_s[b]) m_ctrl[8*b +: 8] = dat_s[8*b +: 8];
                    m_ctrl = m_ctrl & 32'h8000_00FF;
                end else if (adr_s == BASE + 8) begin
                    for (int b = 0; b < 2; b++) if (sel_s[b]) m_guard[8*b +: 8] = dat_s[8*b +: 8];
                end
            end

            la_pipe[1] = la_pipe[0];
            la_pipe[0] = {la_ovr, la_sel};
        end
    end

    // ---------------- Monitor ----------------
    logic [NP-1:0] prev_act = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            logic [NP-1:0] exp_act;
            sb_t           e;
            exp_act = '0;
            if (m_act >= 0) exp_act[m_act] = 1'b1;
            check("active_o", active_o, exp_act);
            check("onehot", {31'b0, ($countones(active_o) > 1)}, 32'h0);
            check("no_overlap", {31'b0, (prev_act != '0 && active_o != '0 && active_o != prev_act)}, 32'h0);
            check("wbs_ack_o", wbs_ack_o, m_ack);
            if (wbs_ack_o) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty_on_ack", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    if (e.rd) check("rdata", wbs_dat_o, e.dat);
                end
            end else begin
                check("dat_idle", wbs_dat_o, 32'h0);
            end
            prev_act = active_o;
        end else begin
            prev_act = '0;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        int n = 0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we_s = we; adr_s = adr; dat_s = dat; sel_s = sel;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 8);
        check("wb_ack_seen", wbs_ack_o, 1'b1);
        rd = wbs_dat_o;
        stb = 1'b0; cyc = 1'b0; we_s = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, dat, 4'hF, dummy);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd);
    endtask

    task automatic wait_active(input logic [NP-1:0] exp, input int limit, output int zeros);
        int n = 0;
        zeros = 0;
        while (active_o !== exp && n < limit) begin
            @(negedge clk);
            n++;
            if (active_o == '0) zeros++;
        end
        check("wait_active", active_o, exp);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_active", active_o, '0);
        check("rst_ack", wbs_ack_o, 1'b0);
        check("rst_dat", wbs_dat_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        logic [31:0] rd;
        int          zeros;
        int          n_ack;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_active", active_o, '0);
        wb_rd(BASE + 4, rd); check("reset_status", rd, 32'h0);
        wb_rd(BASE + 8, rd); check("reset_guard", rd, 32'h4);

        // Enable project 3.
        wb_wr(BASE, 32'h8000_0003);
        @(negedge clk);
        check("enable_latency", active_o, 8'h08);
        wb_rd(BASE + 4, rd); check("status_on3", rd, 32'h203);

        // Switch 3 -> 5 with GUARD = 10.
        wb_wr(BASE + 8, 32'd10);
        wb_wr(BASE, 32'h8000_0005);
        wait_active(8'h20, 40, zeros);
        check("switch_gap", zeros, 32'd11);

        // Reset in the middle of a guard gap.
        wb_wr(BASE, 32'h8000_0003);
        repeat (4) @(negedge clk);
        pulse_reset();
        wb_rd(BASE + 4, rd); check("post_rst_status", rd, 32'h0);
        wb_rd(BASE + 8, rd); check("post_rst_guard", rd, 32'h4);

        // Byte-enable write, unmapped access, held strobe.
        begin
            logic [31:0] dummy;
            wb_xfer(1'b1, BASE, 32'hFFFF_FF06, 4'b0001, dummy);
        end
        wb_rd(BASE, rd); check("byte_write_ctrl", rd, 32'h6);
        wb_wr(BASE + 4, 32'hFFFF_FFFF);
        wb_wr(BASE + 12, 32'hFFFF_FFFF);
        wb_rd(BASE + 12, rd); check("unmapped_read", rd, 32'h0);
        wb_rd(32'h1000_0000, rd); check("outside_read", rd, 32'h0);
        wb_rd(BASE, rd); check("ctrl_after_junk", rd, 32'h6);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we_s = 1'b0; adr_s = BASE + 4; sel_s = 4'hF;
        n_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (wbs_ack_o) n_ack++;
        end
        stb = 1'b0; cyc = 1'b0;
        check("held_strobe_acks", n_ack, 32'd2);

        // Out-of-range selection.
        wb_wr(BASE, 32'h8000_0006);
        wait_active(8'h40, 10, zeros);
        wb_wr(BASE, 32'h8000_0009);
        repeat (10) @(negedge clk);
        check("oor_active", active_o, '0);
        wb_rd(BASE + 4, rd); check("oor_status", rd, 32'h406);

        // LA override takes over, then hands back.
        wb_wr(BASE, 32'h8000_0005);
        wait_active(8'h20, 10, zeros);
        la_ovr = 1'b1; la_sel = 8'd2;
        wait_active(8'h04, 30, zeros);
        check("ovr_gap", zeros, 32'd5);
        wb_rd(BASE + 4, rd); check("ovr_status", rd, 32'hA02);
        la_ovr = 1'b0;
        wait_active(8'h20, 30, zeros);
        check("ovr_release_gap", zeros, 32'd5);

        // Reset while a project is driving.
        pulse_reset();

        // Randomised traffic.
        for (int it = 0; it < 300; it++) begin
            int          op, k;
            logic [31:0] a, d, r;
            logic [3:0]  s;
            op = $urandom_range(0, 7);
            if (op <= 4) begin
                k = $urandom_range(0, 5);
                case (k)
                    0: a = BASE;
                    1: a = BASE + 4;
                    2: a = BASE + 8;
                    3: a = BASE + 12;
                    4: a = BASE + 32'h10;
                    default: a = 32'h1000_0000;
                endcase
                r = $urandom();
                d = r;
                if (k == 2) d[15:0] = {8'h00, 8'($urandom_range(0, 5))};
                else        d[7:0]  = 8'($urandom_range(0, 11));
                s = 4'($urandom_range(0, 15));
                wb_xfer(1'($urandom_range(0, 1)), a, d, s, rd);
            end else if (op == 5) begin
                @(negedge clk);
                la_ovr = ($urandom_range(0, 3) == 0);
                la_sel = 8'($urandom_range(0, 10));
            end else begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
        end

        la_ovr = 1'b0;
        wb_wr(BASE, 32'h0);
        repeat (20) @(negedge clk);
        check("final_active", active_o, '0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
